pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives the hold (enable) and bubble (flush) controls of the IF/ID, ID/EX, EX/MEM and MEM/WB buffer registers, plus the PC update enable.
- Resolves three events: load-use hazards, taken branches resolved in EX, and multi-cycle data-memory accesses signalled by a valid/ready handshake.
- Includes a memory-timeout watchdog and saturating performance counters.

Parameters:
- MEM_TIMEOUT, 255: maximum consecutive MEM_WAIT cycles before fatal error; legal range 1..65535.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs1  in  5  rs1 field of the instruction in IF/ID.
- id_rs2  in  5  rs2 field of the instruction in IF/ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_memread  in  1  MemRead bit of ID/EX.
- ex_rd  in  5  rd of ID/EX.
- ex_branch_taken  in  1  branch/jump in EX redirects the PC.
- mem_req  in  1  MemRead or MemWrite of EX/MEM.
- dmem_ready  in  1  data memory completes the access this cycle.
- dmem_valid  out  1  access request to data memory.
- pc_en  out  1  PC register load enable.
- if_id_en  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID loads zero (NOP).
- id_ex_en  out  1  ID/EX load enable.
- id_ex_flush  out  1  ID/EX loads zero.
- ex_mem_en  out  1  EX/MEM load enable.
- mem_wb_flush  out  1  MEM/WB loads zero.
- timeout_err  out  1  sticky watchdog error.
- stall_cycles  out  CNT_W  saturating count of stall cycles.
- flush_events  out  CNT_W  saturating count of branch flushes.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=RUN, wait counter=0, timeout_err=0, both counters=0.
  - While reset is low, combinationally: all *_en=0, if_id_flush=id_ex_flush=mem_wb_flush=1, dmem_valid=0.
- States:
  - RUN: normal issue.
  - MEM_WAIT: data access outstanding.
  - ERR: fatal; exited only by reset.
- Derived terms:
  - mem_stall = mem_req & ~dmem_ready.
  - lu_hazard = ex_memread & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - x0 never creates a hazard.
- dmem_valid = mem_req in RUN and MEM_WAIT; 0 in ERR. The request is held stable until dmem_ready.
- Output priority in RUN/MEM_WAIT, highest first:
  1. mem_stall: pc_en=if_id_en=id_ex_en=ex_mem_en=0, mem_wb_flush=1, other flushes=0. Taken branches and load-use are held, not acted on.
  2. ex_branch_taken: all en=1, if_id_flush=1, id_ex_flush=1. Branch beats load-use in the same cycle.
  3. lu_hazard: pc_en=if_id_en=0, id_ex_en=1, id_ex_flush=1, ex_mem_en=1. Exactly one bubble is inserted, because the load moves to MEM next cycle.
  4. Otherwise: all en=1, all flush=0.
- ERR state outputs: all en=0, all flush=0, dmem_valid=0. Pipeline is frozen.
- Transitions (registered, rising edge):
  - RUN→MEM_WAIT when mem_stall; wait counter←1.
  - MEM_WAIT→RUN when dmem_ready; counter←0.
  - MEM_WAIT stays while mem_stall; counter+1.
  - MEM_WAIT→ERR when mem_stall and counter==MEM_TIMEOUT; timeout_err←1 (sticky).
  - If dmem_ready arrives in the same cycle as the timeout condition, ready wins → RUN.
  - A single-cycle access (ready in the same cycle as req) never leaves RUN.
  - Back-to-back accesses: each new mem_stall in RUN re-enters MEM_WAIT with counter=1.
- Counters:
  - stall_cycles +1 every cycle pc_en=0 in RUN/MEM_WAIT.
  - flush_events +1 every cycle the branch-flush row is active.
  - Both saturate at all-ones; no wrap.
- Latency: all enable/flush outputs are combinational from inputs and state; zero added cycles.
- Reset mid-MEM_WAIT aborts the wait: state returns to RUN and the counters clear.

Test Plan:
- Load x5 in EX (ex_memread=1, ex_rd=5), ID reads rs1=5 → one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all en=1; stall_cycles=1.
- Same, but ex_rd=0 and rs1=0 → no stall; stall_cycles stays 0.
- ex_branch_taken=1 together with lu_hazard=1 → if_id_flush=id_ex_flush=1, pc_en=1; flush_events=1, stall_cycles=0.
- mem_req=1, dmem_ready low for 3 cycles, then high:
  - state enters MEM_WAIT for 3 cycles with ex_mem_en=0 and mem_wb_flush=1, then returns to RUN.
  - A branch asserted during the wait is applied only on the ready cycle.
  - stall_cycles=3.
- MEM_TIMEOUT=4, dmem_ready held 0 → after 5 stall cycles timeout_err=1, state ERR, dmem_valid=0; deassert and reassert reset → timeout_err=0, state RUN.
- Force stall_cycles to saturate (CNT_W=4, 20 stall cycles) → holds at 15; assert reset mid-MEM_WAIT → outputs take their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use, branch redirect, multi-cycle dmem.
// Enables/flushes are combinational (zero latency); mem_stall freezes IF..EX until dmem_ready.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             dmem_valid,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_flush,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_e;

  localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [15:0]      wcnt_q, wcnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic mem_stall;
  logic lu_hazard;
  logic br_flush;

  assign mem_stall = mem_req & ~dmem_ready;
  assign lu_hazard = ex_memread & (ex_rd != 5'd0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    dmem_valid   = mem_req;
    br_flush     = 1'b0;
    if (!reset) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
      dmem_valid   = 1'b0;
    end else if (state_q == ERR) begin
      pc_en      = 1'b0;
      if_id_en   = 1'b0;
      id_ex_en   = 1'b0;
      ex_mem_en  = 1'b0;
      dmem_valid = 1'b0;
    end else if (mem_stall) begin
      // Branch and load-use stay parked in their stages until the access completes.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      br_flush    = 1'b1;
    end else if (lu_hazard) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          wcnt_d  = 16'd1;
        end
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_d = RUN;
          wcnt_d  = 16'd0;
        end else if (wcnt_q == TIMEOUT) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      default: state_d = ERR;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if ((state_q != ERR) && !pc_en && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + CNT_W'(1);
    if (br_flush && (flush_q != {CNT_W{1'b1}}))
      flush_d = flush_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      wcnt_q  <= 16'd0;
      err_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign timeout_err  = err_q;
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: vector table on a default instance plus multi-cycle sequences;
// a small instance (MEM_TIMEOUT=4, CNT_W=4) covers watchdog and saturation corners.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_memread = 1'b0;
  logic ex_branch_taken = 1'b0, mem_req = 1'b0, dmem_ready = 1'b0;

  logic dv_a, pc_a, ifen_a, iff_a, idexen_a, idexf_a, exmem_a, mwbf_a, err_a;
  logic [15:0] stall_a, flush_a;
  logic dv_b, pc_b, ifen_b, iff_b, idexen_b, idexf_b, exmem_b, mwbf_b, err_b;
  logic [3:0] stall_b, flush_b;

  logic [7:0] oa, ob;
  assign oa = {pc_a, ifen_a, iff_a, idexen_a, idexf_a, exmem_a, mwbf_a, dv_a};
  assign ob = {pc_b, ifen_b, iff_b, idexen_b, idexf_b, exmem_b, mwbf_b, dv_b};

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut_a (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
    .dmem_ready(dmem_ready), .dmem_valid(dv_a), .pc_en(pc_a), .if_id_en(ifen_a),
    .if_id_flush(iff_a), .id_ex_en(idexen_a), .id_ex_flush(idexf_a),
    .ex_mem_en(exmem_a), .mem_wb_flush(mwbf_a), .timeout_err(err_a),
    .stall_cycles(stall_a), .flush_events(flush_a)
  );

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
    .dmem_ready(dmem_ready), .dmem_valid(dv_b), .pc_en(pc_b), .if_id_en(ifen_b),
    .if_id_flush(iff_b), .id_ex_en(idexen_b), .id_ex_flush(idexf_b),
    .ex_mem_en(exmem_b), .mem_wb_flush(mwbf_b), .timeout_err(err_b),
    .stall_cycles(stall_b), .flush_events(flush_b)
  );

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, memread, br, mreq, rdy;
    logic [7:0] exp;   // {pc,if_id_en,if_id_flush,id_ex_en,id_ex_flush,ex_mem_en,mem_wb_flush,dmem_valid}
  } vec_t;

  vec_t vecs[13];
  int errors = 0;
  int checks = 0;

  localparam logic [7:0] O_IDLE  = 8'b11010100;
  localparam logic [7:0] O_LU    = 8'b00011100;
  localparam logic [7:0] O_BR    = 8'b11111100;
  localparam logic [7:0] O_MSTL  = 8'b00000011;
  localparam logic [7:0] O_RST   = 8'b00101010;
  localparam logic [7:0] O_ERR   = 8'b00000000;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drv(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic u1, input logic u2, input logic mr, input logic br,
                     input logic mq, input logic rdy);
    id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_memread = mr; ex_branch_taken = br; mem_req = mq; dmem_ready = rdy;
  endtask

  task automatic idle();
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE};
    vecs[1]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
    vecs[2]  = '{5'd0, 5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
    vecs[3]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_IDLE};
    vecs[4]  = '{5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_IDLE};
    vecs[5]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE};
    vecs[6]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, O_BR};
    vecs[7]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'b11010101};
    vecs[8]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_MSTL};
    vecs[9]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, O_MSTL};
    vecs[10] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'b11111101};
    vecs[11] = '{5'd0, 5'd9, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
    vecs[12] = '{5'd5, 5'd6, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_IDLE};

    // Reset state, with live requests that must be masked.
    drv(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    #3;
    chk("rst_outs_a", oa, O_RST);
    chk("rst_outs_b", ob, O_RST);
    chk("rst_err", err_a, 0);
    chk("rst_stall", stall_a, 0);
    chk("rst_flush", flush_a, 0);
    do_reset();

    for (int i = 0; i < 13; i++) begin
      drv(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].use1, vecs[i].use2,
          vecs[i].memread, vecs[i].br, vecs[i].mreq, vecs[i].rdy);
      @(negedge clk);
      chk($sformatf("vec%0d", i), oa, vecs[i].exp);
      step();
    end

    // Load-use: exactly one bubble.
    do_reset();
    drv(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lu_stall", oa, O_LU);
    step();
    drv(5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lu_next", oa, O_IDLE);
    chk("lu_stall_cnt", stall_a, 1);

    // x0 never hazards.
    do_reset();
    drv(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("x0_outs", oa, O_IDLE);
    step();
    chk("x0_stall_cnt", stall_a, 0);

    // Branch beats load-use.
    do_reset();
    drv(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("br_lu_outs", oa, O_BR);
    step();
    idle();
    @(negedge clk);
    chk("br_flush_cnt", flush_a, 1);
    chk("br_stall_cnt", stall_a, 0);

    // Three-cycle memory wait, branch held until the ready cycle.
    do_reset();
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("mw_cyc%0d", c), oa, O_MSTL);
      step();
      drv(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    chk("mw_ready", oa, 8'b11111101);
    step();
    idle();
    @(negedge clk);
    chk("mw_after", oa, O_IDLE);
    chk("mw_stall_cnt", stall_a, 3);
    chk("mw_flush_cnt", flush_a, 1);
    chk("mw_no_err", err_a, 0);

    // Watchdog on the small instance.
    do_reset();
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) @(posedge clk);
    @(negedge clk);
    chk("to_not_yet", err_b, 0);
    chk("to_wait_outs", ob, O_MSTL);
    @(negedge clk);
    chk("to_err", err_b, 1);
    chk("to_err_outs", ob, O_ERR);
    chk("to_stall_cnt", stall_b, 5);
    @(negedge clk);
    @(negedge clk);
    chk("to_err_sticky", err_b, 1);
    chk("to_err_frozen_cnt", stall_b, 5);
    #1 reset = 1'b0;
    #1;
    chk("to_rst_err", err_b, 0);
    chk("to_rst_outs", ob, O_RST);
    #1 reset = 1'b1;
    #1;
    chk("to_run_outs", ob, O_MSTL);

    // Ready on the timeout cycle wins.
    do_reset();
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) @(posedge clk);
    #1 dmem_ready = 1'b1;
    @(negedge clk);
    chk("rw_ready_outs", ob, 8'b11010101);
    step();
    idle();
    @(negedge clk);
    chk("rw_no_err", err_b, 0);
    chk("rw_run_outs", ob, O_IDLE);

    // Saturation, then asynchronous reset in the middle of a memory wait.
    do_reset();
    drv(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) @(posedge clk);
    #1;
    chk("sat_stall_cnt", stall_b, 15);
    chk("sat_wide_cnt", stall_a, 20);
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    step();
    @(negedge clk);
    chk("sat_hold", stall_b, 15);
    chk("mid_wait_outs", ob, O_MSTL);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_outs", ob, O_RST);
    chk("mid_rst_stall", stall_b, 0);
    chk("mid_rst_stall_a", stall_a, 0);
    #1 reset = 1'b1;
    idle();
    @(negedge clk);
    chk("mid_rst_run", ob, O_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
